// File: rtl/ds_mod1_dac.sv
// First-order delta-sigma modulator.
// Takes one signed W-bit sample every OSR clocks over a valid/ready handshake
// and produces a 1-bit oversampled bitstream for the analog output filter.
module ds_mod1_dac #(
    parameter int W     = 16,
    parameter int OSR   = 64,
    parameter int ACC_W = W + 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dout,
    output logic         dout_valid,
    output logic         sample_tick,
    output logic         underrun,
    output logic         ovf
);

    localparam int CNT_W = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    // Feedback levels: +FS = 2^(W-1)-1, -FS = -(2^(W-1)) which is the bitwise inverse of +FS.
    localparam logic signed [ACC_W-1:0] FB_POS  = ACC_W'((2 ** (W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] FB_NEG  = ~FB_POS;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0]        osr_cnt_reg, osr_cnt_next;
    logic [W-1:0]            x_reg, x_next;
    logic                    dout_reg, dout_next;
    logic                    dout_valid_reg, dout_valid_next;
    logic                    sample_tick_reg, sample_tick_next;
    logic                    underrun_reg, underrun_next;
    logic                    ovf_reg, ovf_next;
    logic                    ready_c;
    logic                    handshake;
    logic                    boundary;

    // Datapath signals
    logic signed [ACC_W-1:0] fb;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] d;
    logic signed [ACC_W:0]   s_wide;
    logic                    sat_hi;
    logic                    sat_lo;
    logic signed [ACC_W-1:0] acc_sat;

    assign boundary  = (osr_cnt_reg == CNT_LAST);
    assign handshake = ready_c & din_valid;

    // Previous output bit selects the feedback level.
    assign fb    = dout_reg ? FB_POS : FB_NEG;
    assign x_ext = {{(ACC_W - W){x_reg[W-1]}}, x_reg};
    // Subtraction done as x + ~fb + 1 in ACC_W bits.
    assign d     = x_ext + (~fb) + ACC_W'(1);
    // One extra bit so that integrator overflow is visible before clamping.
    assign s_wide  = {acc_reg[ACC_W-1], acc_reg} + {d[ACC_W-1], d};
    assign sat_hi  = ~s_wide[ACC_W] & s_wide[ACC_W-1];
    assign sat_lo  = s_wide[ACC_W] & ~s_wide[ACC_W-1];
    assign acc_sat = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : s_wide[ACC_W-1:0]);

    // Next-state and handshake logic for the IDLE/RUN controller and integrator.
    always_comb begin
        state_next       = state_reg;
        acc_next         = acc_reg;
        osr_cnt_next     = osr_cnt_reg;
        x_next           = x_reg;
        dout_next        = dout_reg;
        dout_valid_next  = dout_valid_reg;
        sample_tick_next = 1'b0;
        underrun_next    = underrun_reg;
        ovf_next         = ovf_reg;
        ready_c          = 1'b0;

        case (state_reg)
            IDLE: begin
                ready_c         = en;
                acc_next        = '0;
                dout_next       = 1'b0;
                dout_valid_next = 1'b0;
                osr_cnt_next    = '0;
                if (handshake) begin
                    x_next           = din;
                    sample_tick_next = 1'b1;
                    state_next       = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    // Disable drops back to IDLE; sticky flags survive.
                    state_next      = IDLE;
                    acc_next        = '0;
                    dout_next       = 1'b0;
                    dout_valid_next = 1'b0;
                    osr_cnt_next    = '0;
                end else begin
                    ready_c         = boundary;
                    acc_next        = acc_sat;
                    dout_next       = ~s_wide[ACC_W];
                    dout_valid_next = 1'b1;
                    if (sat_hi || sat_lo) begin
                        ovf_next = 1'b1;
                    end
                    if (boundary) begin
                        osr_cnt_next = '0;
                        if (handshake) begin
                            x_next           = din;
                            sample_tick_next = 1'b1;
                        end else begin
                            // Keep modulating the previous sample.
                            underrun_next = 1'b1;
                        end
                    end else begin
                        osr_cnt_next = osr_cnt_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            osr_cnt_reg     <= '0;
            x_reg           <= '0;
            dout_reg        <= 1'b0;
            dout_valid_reg  <= 1'b0;
            sample_tick_reg <= 1'b0;
            underrun_reg    <= 1'b0;
            ovf_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            acc_reg         <= acc_next;
            osr_cnt_reg     <= osr_cnt_next;
            x_reg           <= x_next;
            dout_reg        <= dout_next;
            dout_valid_reg  <= dout_valid_next;
            sample_tick_reg <= sample_tick_next;
            underrun_reg    <= underrun_next;
            ovf_reg         <= ovf_next;
        end
    end

    // No sample is offered as accepted while reset is held.
    assign din_ready   = ready_c & ~rst;
    assign dout        = dout_reg;
    assign dout_valid  = dout_valid_reg;
    assign sample_tick = sample_tick_reg;
    assign underrun    = underrun_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_ds_mod1_dac.sv
// Directed bench for ds_mod1_dac: per-window bit-density scoreboard plus
// handshake, extreme-input, underrun and asynchronous-reset checks.
module tb_ds_mod1_dac;

    localparam int W   = 16;
    localparam int OSR = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready;
    logic         dout;
    logic         dout_valid;
    logic         sample_tick;
    logic         underrun;
    logic         ovf;

    always #5 clk = ~clk;

    ds_mod1_dac #(.W(W), .OSR(OSR), .ACC_W(W + 2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sample_tick(sample_tick),
        .underrun   (underrun),
        .ovf        (ovf)
    );

    typedef struct {
        int ones;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   passes   = 0;
    int   total    = 0;
    bit   win_on   = 1'b0;
    int   win_ones = 0;
    int   win_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passes++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) passes++;
        else $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    endtask

    // One clock: sample at the falling edge and run the window scoreboard.
    // A window is the OSR dout bits following a sample_tick pulse.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (win_on && dout_valid) begin
            win_ones += int'(dout);
            win_cnt++;
            if (win_cnt == OSR) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    $display("window: ones=%0d expected=%0d+/-%0d", win_ones, e.ones, e.tol);
                    check_range("density", win_ones, e.ones - e.tol, e.ones + e.tol);
                end
                win_ones = 0;
                win_cnt  = 0;
            end
        end
        if (sample_tick) begin
            win_on   = 1'b1;
            win_ones = 0;
            win_cnt  = 0;
        end else if (!dout_valid) begin
            win_on = 1'b0;
        end
    endtask

    task automatic run_until_empty();
        int budget;
        budget = OSR * (sb.size() + 2);
        for (int i = 0; i < budget && sb.size() > 0; i++) tick();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2 * OSR && !din_ready; i++) tick();
        check("ready_seen", din_ready, 1);
    endtask

    // Offer v at the next boundary, then score nwin windows of it.
    task automatic load(input logic [W-1:0] v, input int ones, input int tol1, input int nwin);
        din       = v;
        din_valid = 1'b1;
        wait_ready();
        tick();
        check("load_tick", sample_tick, 1);
        $display("sample %04h accepted", v);
        sb.delete();
        sb.push_back('{ones, tol1});
        for (int i = 1; i < nwin; i++) sb.push_back('{ones, 1});
        run_until_empty();
    endtask

    // Leave RUN via en, then restart from IDLE with v; checks the first RUN bit.
    task automatic idle_restart(input logic [W-1:0] v);
        sb.delete();
        en = 1'b0;
        tick();
        check("idle_outs", {dout_valid, dout}, 0);
        en        = 1'b1;
        din       = v;
        din_valid = 1'b1;
        #1;
        check("idle_ready", din_ready, 1);
        tick();
        check("restart_tick", sample_tick, 1);
        tick();
        check("first_run_bit", dout, 1);
        $display("restart with %04h", v);
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        en        = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_outs", {dout, dout_valid, din_ready, sample_tick, underrun, ovf}, 0);

        // Zero input from IDLE.
        en        = 1'b1;
        din       = 16'h0000;
        din_valid = 1'b1;
        #1;
        check("idle_ready_en", din_ready, 1);
        tick();
        check("first_tick", sample_tick, 1);
        $display("sample 0000 accepted");
        for (int i = 0; i < 4; i++) sb.push_back('{32, 1});
        cnt = 0;
        for (int i = 0; i < OSR; i++) begin
            tick();
            cnt += int'(din_ready);
        end
        check("ready_pulses", cnt, 1);
        check("dout_valid_run", dout_valid, 1);
        run_until_empty();
        check("underrun_zero", underrun, 0);
        check("ovf_zero", ovf, 0);

        // Half-scale inputs.
        load(16'h4000, 48, 2, 3);
        load(16'hC000, 16, 2, 3);

        // Handshake timing: 0x0000 then 0x7FFF at the next boundary.
        load(16'h0000, 32, 2, 1);
        sb.delete();
        din = 16'h7FFF;
        wait_ready();
        check("pre_tick", sample_tick, 0);
        tick();
        check("tick_after_accept", sample_tick, 1);
        tick();
        check("tick_single", sample_tick, 0);
        cnt = 0;
        for (int i = 0; i < OSR - 1; i++) begin
            tick();
            cnt += int'(dout);
        end
        check("full_scale_ones", cnt, OSR - 1);
        $display("0x7FFF after boundary: ones=%0d", cnt);

        // Extremes from IDLE.
        idle_restart(16'h8000);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cnt += int'(dout);
        end
        check("neg_fs_tail", cnt, 0);
        idle_restart(16'h7FFF);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            cnt += int'(dout);
        end
        check("pos_fs_tail", cnt, 60);
        check("ovf_extremes", ovf, 0);
        check("underrun_before", underrun, 0);

        // Underrun: drop din_valid on one boundary while a different value sits on din.
        load(16'h4000, 48, 2, 1);
        sb.push_back('{48, 1});
        sb.push_back('{48, 1});
        wait_ready();
        din_valid = 1'b0;
        din       = 16'hC000;
        tick();
        check("underrun_set", underrun, 1);
        check("no_tick_underrun", sample_tick, 0);
        $display("boundary skipped, underrun=%0b", underrun);
        din       = 16'h4000;
        din_valid = 1'b1;
        sb.push_back('{48, 1});
        run_until_empty();
        check("underrun_sticky", underrun, 1);

        // Asynchronous reset at cycle 37 of a window.
        repeat (37) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outs", {dout, dout_valid, din_ready, sample_tick, underrun, ovf}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset_ready", din_ready, 1);
        check("post_reset_valid", dout_valid, 0);
        din       = 16'hC000;
        din_valid = 1'b1;
        tick();
        check("post_reset_tick", sample_tick, 1);
        check("post_reset_underrun", underrun, 0);
        $display("sample c000 accepted after reset");
        sb.delete();
        sb.push_back('{16, 1});
        sb.push_back('{16, 1});
        run_until_empty();
        check("ovf_final", ovf, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ds_mod1_dac.md
Name: ds_mod1_dac

Overview:
- First-order delta-sigma modulator. Consumes a stream of 16-bit two's-complement samples and produces a 1-bit oversampled bitstream for the analog output filter.
- Sits directly downstream of the datapath's 16-bit inversion stage.
- The feedback subtraction is performed as "x + ones'-complement(fb) + 1".
- One new sample is requested every OSR clock cycles through a valid/ready handshake.

Parameters:
- W, 16, input sample width (two's complement).
- OSR, 64, clock cycles per input sample (oversampling ratio, >= 2).
- ACC_W, W+2, integrator width, signed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  modulator enable.
- din  in  W  input sample, signed two's complement.
- din_valid  in  1  upstream has a sample on din.
- din_ready  out  1  block will accept din this cycle.
- dout  out  1  modulator bitstream (1 = +FS, 0 = -FS).
- dout_valid  out  1  high while dout carries valid modulator output.
- sample_tick  out  1  one-cycle pulse when a new sample is loaded.
- underrun  out  1  sticky: sample boundary passed without a handshake.
- ovf  out  1  sticky: integrator saturated.

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE, acc=0, osr_cnt=0, x_reg=0.
  - dout=0, dout_valid=0, din_ready=0, sample_tick=0, underrun=0, ovf=0.
- States: IDLE, RUN.
- IDLE:
  - din_ready = en.
  - On din_valid & din_ready: x_reg<=din, osr_cnt<=0, sample_tick=1 next cycle, go to RUN.
  - acc and dout are held at 0 in IDLE.
- RUN, every cycle:
  - fb = dout ? +(2^(W-1)-1) : -(2^(W-1)), sign-extended to ACC_W.
  - d = x_reg + ~fb + 1, computed in ACC_W bits.
  - s = acc + d.
  - acc <= sat(s). dout <= (s >= 0). dout_valid <= 1.
  - osr_cnt increments and wraps from OSR-1 to 0.
- din_ready in RUN: asserted only in the cycle where osr_cnt==OSR-1 (combinational from osr_cnt and state).
- Sample boundary (osr_cnt==OSR-1):
  - Handshake occurs: x_reg<=din, used from the next cycle; sample_tick pulses the following cycle.
  - No handshake: x_reg is held, underrun<=1 (sticky until rst).
- Latency:
  - A sample accepted at cycle n first affects the integrator at cycle n+1.
  - It first affects dout at cycle n+2.
- Saturation:
  - sat clamps s to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1].
  - Any clamp sets ovf (sticky).
  - With ACC_W=W+2, clamping is unreachable for legal input; ovf flags a design error.
- en deasserted in RUN: go to IDLE next cycle; acc=0, dout=0, dout_valid=0, osr_cnt=0. underrun and ovf are held.
- en deasserted and din_valid in the same boundary cycle: no handshake (din_ready=0), return to IDLE.
- en toggled back high: restarts from IDLE with a fresh handshake; the previous x_reg is not reused.
- rst asserted mid-RUN: all state clears asynchronously. The first post-reset edge is in IDLE.
- Bit density: the fraction of ones over a full OSR window is approximately (x+2^(W-1))/(2^W-1), within ±1 bit per window.

Test Plan:
- Zero input: en=1, din=0x0000 held with din_valid=1. After the first window, each 64-cycle window has 32±1 ones, and din_ready pulses exactly once per 64 cycles. underrun=0, ovf=0.
- Input 0x4000 (+16384): 48±1 ones per window. Input 0xC000 (-16384): 16±1 ones per window.
- Extremes:
  - 0x7FFF: after the first RUN cycle, dout=1 on every cycle.
  - 0x8000: the first RUN bit is 1, then dout=0 on every cycle.
  - ovf stays 0 in both cases.
- Underrun: drop din_valid during one boundary cycle. underrun rises and stays 1, the previous sample continues (same density), and sample_tick is absent for that window.
- Handshake timing: present 0x0000, then 0x7FFF at the next boundary. sample_tick is seen one cycle after the boundary, and the density change starts 2 cycles after acceptance.
- Async reset mid-RUN (cycle 37 of a window): all outputs go to 0 without waiting for a clock edge. After release with en=1, din_ready=1 in IDLE and a new handshake restarts the stream.
